frame_tx_mc: RTL and testbench
==============================

Name: frame_tx_mc

Overview:
Parametrised successor to the current frame transmitter, running from a single clock. Host side writes data words into a shared buffer, then commits them as a frame or rolls them back. Committed frames are queued and sent on LANES parallel serial lines, framed by preamble and gap, with a programmable bit-slot divider. Sits between the host command decoder and the physical TX pins; status and interrupt go back to the host register interface.

Parameters:
DATA_W, 8, data word width; must be >=8 and a multiple of LANES
LANES, 1, number of parallel TX lines
DEPTH, 16, data buffer depth in words (power of 2)
MAX_FRAMES, 4, committed-frame descriptor FIFO depth (power of 2)
BIT_DIV, 1, clock cycles per bit slot (>=1)
PREAMBLE_LEN, 4, preamble length in slots
GAP_LEN, 2, inter-frame gap length in slots

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_data  in  DATA_W  write data
i_data_we  in  1  write strobe: append i_data to uncommitted frame
i_push_frame  in  1  commit uncommitted words as one frame
i_rollback  in  1  discard uncommitted words
i_clr_err  in  1  clear sticky error bits
o_data_size  out  $clog2(DEPTH)+1  uncommitted word count
o_frames_count  out  $clog2(MAX_FRAMES)+1  committed frames not yet fully sent, including the one in flight
o_status  out  8  [0] no committed frames, [1] buffer full, [2] frame FIFO full, [3] busy (state != IDLE), [4] overflow (sticky), [5] empty push (sticky), [7:6] 0
o_tx  out  LANES  serial data
o_tx_en  out  1  high during PREAMBLE and DATA
o_tx_int  out  1  one-cycle pulse at end of each frame's data

Behaviour:
- Reset (asynchronous, immediate): all outputs 0 except o_status = 0x01; buffers, counters and FSM cleared. Reset mid-frame aborts transmission at once.
- Buffer occupancy is committed words plus uncommitted words. A word is freed when the serializer loads it.
- Full: occupancy == DEPTH.
- Write while full: the word is dropped and status[4] is set.
- i_push_frame behaviour:
  - uncommitted == 0: ignored; sets status[5].
  - frame FIFO full: ignored; sets status[4], and uncommitted data is kept.
  - otherwise: stores a {start, length} descriptor; o_data_size returns to 0.
- Simultaneous events:
  - i_data_we with i_push_frame: the word is included in the frame.
  - i_rollback with i_data_we: rollback wins and the word is dropped.
  - i_rollback with i_push_frame: push wins.
- Pointer arithmetic wraps modulo DEPTH and MAX_FRAMES.
- FSM states: IDLE, PREAMBLE, DATA, GAP.
  - IDLE -> PREAMBLE when a committed frame exists. A push sampled at edge t gives o_tx_en = 1 after edge t+1.
  - PREAMBLE: PREAMBLE_LEN slots. Slot k drives all lanes = ~k[0], giving 1,0,1,0...
  - DATA: each word takes DATA_W/LANES slots, MSB first. In slot s, o_tx = word[DATA_W-1-s*LANES -: LANES].
  - DATA -> GAP after the last slot. o_tx_int pulses on the first GAP cycle, and o_frames_count decrements in that same cycle.
  - GAP: GAP_LEN slots with o_tx = 0 and o_tx_en = 0. Then -> PREAMBLE if another frame is queued, else IDLE.
- Each slot is held exactly BIT_DIV cycles. All TX outputs are registered.
- Writes, pushes and rollbacks are accepted in every state; an in-flight frame is unaffected.
- i_clr_err clears status[5:4]. If an error occurs in the same cycle, the error wins.

Optional Feature:
FRAME_TX_CRC_EN
- Defined: a CRC-8 (poly 0x07, init 0x00, MSB first, over all DATA_W bits of each frame word) is appended as one extra DATA word, zero-extended to DATA_W. The CRC word is not counted in the buffer.
- Undefined: no CRC logic; DATA ends after the last buffer word.

Test Plan:
1. Defaults; write 0xA5, 0x3C, push -> o_tx_en high 20 cycles; o_tx = 1010 then 10100101 00111100; o_tx_int pulse; o_frames_count 1 -> 0; status[3] returns to 0 after 2 gap cycles.
2. Write 3 words, i_rollback -> o_data_size 0; o_tx_en never rises; o_status = 0x01.
3. Write 17 words -> status[1] = 1 after 16 writes; 17th dropped; status[4] = 1. Push sends exactly 16 words. i_clr_err -> status[4] = 0.
4. With the transmitter busy, commit 5 one-word frames -> 5th push ignored; status[2] = 1; status[4] = 1; 4 frames sent back-to-back with 2-slot gaps.
5. LANES=2, BIT_DIV=3, frame 0xC6 -> lane pairs 11,00,01,10, each held 3 cycles.
6. Reset asserted mid-DATA -> o_tx, o_tx_en, counts = 0 immediately. With FRAME_TX_CRC_EN, frame {0x01} -> data 0x01 followed by CRC 0x07.

Source files
------------

// File: rtl/frame_tx_mc.sv
// frame_tx_mc: buffered multi-lane frame transmitter.
// The host appends words, then commits them as a frame or rolls them back.
// Committed frames are queued as {start, length} descriptors and sent as
// preamble, data and gap on LANES serial lines. Each bit slot lasts BIT_DIV
// clocks.
// Optional macro FRAME_TX_CRC_EN appends a CRC-8 word (poly 0x07, init 0x00)
// to every frame.
module frame_tx_mc #(
    parameter int DATA_W       = 8,
    parameter int LANES        = 1,
    parameter int DEPTH        = 16,
    parameter int MAX_FRAMES   = 4,
    parameter int BIT_DIV      = 1,
    parameter int PREAMBLE_LEN = 4,
    parameter int GAP_LEN      = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_data_we,
    input  logic                          i_push_frame,
    input  logic                          i_rollback,
    input  logic                          i_clr_err,
    output logic [$clog2(DEPTH):0]        o_data_size,
    output logic [$clog2(MAX_FRAMES):0]   o_frames_count,
    output logic [7:0]                    o_status,
    output logic [LANES-1:0]              o_tx,
    output logic                          o_tx_en,
    output logic                          o_tx_int
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int FW    = $clog2(MAX_FRAMES);
    localparam int NW    = FW + 1;
    localparam int SLOTS = DATA_W / LANES;
    localparam int MAXPG = (PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN;
    localparam int MAXS  = (SLOTS > MAXPG) ? SLOTS : MAXPG;
    localparam int SW    = $clog2(MAXS) + 1;
    localparam int DW    = $clog2(BIT_DIV) + 1;

    localparam logic [SW-1:0] PRE_LAST = SW'(PREAMBLE_LEN - 1);
    localparam logic [SW-1:0] DAT_LAST = SW'(SLOTS - 1);
    localparam logic [SW-1:0] GAP_LAST = SW'(GAP_LEN - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

    // ---------------- host side: buffer and descriptor queue ----------------
    logic [DATA_W-1:0] mem        [DEPTH];
    logic [AW-1:0]     desc_start [MAX_FRAMES];
    logic [CW-1:0]     desc_len   [MAX_FRAMES];

    logic [AW-1:0] wr_ptr, cm_ptr;     // write position, start of uncommitted run
    logic [CW-1:0] unc_cnt, com_cnt;   // uncommitted words, committed-not-loaded words
    logic [FW-1:0] d_head, d_tail;
    logic [NW-1:0] d_cnt;              // includes the frame in flight
    logic          err_ovf, err_empty;

    logic          buf_full, fifo_full, we_ok, do_push, do_rb;
    logic          ovf_set, empty_set;
    logic [CW-1:0] unc_tot;

    // serializer handshake into the host side
    logic          ld_word, pop;

    assign buf_full  = (com_cnt + unc_cnt) == CW'(DEPTH);
    assign fifo_full = d_cnt == NW'(MAX_FRAMES);
    // rollback drops a simultaneous write; a full buffer drops it too
    assign we_ok     = i_data_we && !i_rollback && !buf_full;
    // a write in the same cycle as a push belongs to the pushed frame
    assign unc_tot   = unc_cnt + CW'(we_ok);
    assign do_push   = i_push_frame && (unc_tot != '0) && !fifo_full;
    assign do_rb     = i_rollback && !i_push_frame;
    assign ovf_set   = (i_data_we && !i_rollback && buf_full) ||
                       (i_push_frame && (unc_tot != '0) && fifo_full);
    assign empty_set = i_push_frame && (unc_tot == '0);

    // storage arrays: data words and frame descriptors (no reset needed)
    always_ff @(posedge i_clk) begin
        if (we_ok) mem[wr_ptr] <= i_data;
        if (do_push) begin
            desc_start[d_tail] <= cm_ptr;
            desc_len[d_tail]   <= unc_tot;
        end
    end

    // pointers, occupancy counters and sticky error bits
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr    <= '0;
            cm_ptr    <= '0;
            unc_cnt   <= '0;
            com_cnt   <= '0;
            d_head    <= '0;
            d_tail    <= '0;
            d_cnt     <= '0;
            err_ovf   <= 1'b0;
            err_empty <= 1'b0;
        end else begin
            if (do_rb)      wr_ptr <= cm_ptr;
            else if (we_ok) wr_ptr <= wr_ptr + 1'b1;
            if (do_push)    cm_ptr <= wr_ptr + AW'(we_ok);
            unc_cnt   <= (do_push || do_rb) ? '0 : unc_tot;
            com_cnt   <= com_cnt + (do_push ? unc_tot : '0) - CW'(ld_word);
            if (do_push) d_tail <= d_tail + 1'b1;
            if (pop)     d_head <= d_head + 1'b1;
            d_cnt     <= d_cnt + NW'(do_push) - NW'(pop);
            // a new error in the same cycle beats the clear
            err_ovf   <= ovf_set   | (err_ovf   & ~i_clr_err);
            err_empty <= empty_set | (err_empty & ~i_clr_err);
        end
    end

    // ---------------- serializer ----------------
    state_t            state, nxt_state;
    logic [DW-1:0]     div_cnt, nxt_div;
    logic [SW-1:0]     slot_cnt, nxt_slot;
    logic [CW-1:0]     wleft, nxt_wleft;    // buffer words still to load
    logic [DATA_W-1:0] shreg, nxt_shreg, ld_data;
    logic [AW-1:0]     rd_ptr, nxt_rd;
    logic [LANES-1:0]  nxt_tx;
    logic              nxt_en, nxt_int, go_gap, slot_end;

`ifdef FRAME_TX_CRC_EN
    logic [7:0] crc, nxt_crc;
    logic       crc_ph, nxt_crc_ph;         // CRC word already loaded

    function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [DATA_W-1:0] w);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[7] ^ w[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction
`endif

    assign slot_end = (div_cnt == DIV_LAST);

    // next-state, slot sequencing and next values of the registered TX pins
    always_comb begin
        nxt_state = state;
        nxt_div   = '0;
        nxt_slot  = slot_cnt;
        nxt_wleft = wleft;
        nxt_shreg = shreg;
        nxt_rd    = rd_ptr;
        nxt_tx    = o_tx;
        nxt_en    = o_tx_en;
        nxt_int   = 1'b0;
        ld_word   = 1'b0;
        pop       = 1'b0;
        go_gap    = 1'b0;
        ld_data   = mem[rd_ptr];
`ifdef FRAME_TX_CRC_EN
        nxt_crc    = crc;
        nxt_crc_ph = crc_ph;
`endif
        if (state != IDLE) nxt_div = slot_end ? '0 : div_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (d_cnt != '0) begin
                    nxt_state = PREAMBLE;
                    nxt_slot  = '0;
                    nxt_tx    = {LANES{1'b1}};
                    nxt_en    = 1'b1;
                end
            end
            PREAMBLE: begin
                if (slot_end) begin
                    if (slot_cnt == PRE_LAST) begin
                        // first word comes from the head descriptor
                        ld_data   = mem[desc_start[d_head]];
                        nxt_state = DATA;
                        nxt_slot  = '0;
                        nxt_shreg = ld_data;
                        nxt_rd    = desc_start[d_head] + 1'b1;
                        nxt_wleft = desc_len[d_head] - 1'b1;
                        nxt_tx    = ld_data[DATA_W-1 -: LANES];
                        ld_word   = 1'b1;
`ifdef FRAME_TX_CRC_EN
                        nxt_crc    = crc_upd(8'h00, ld_data);
                        nxt_crc_ph = 1'b0;
`endif
                    end else begin
                        nxt_slot = slot_cnt + 1'b1;
                        nxt_tx   = {LANES{~nxt_slot[0]}};
                    end
                end
            end
            DATA: begin
                if (slot_end) begin
                    if (slot_cnt == DAT_LAST) begin
                        nxt_slot = '0;
                        if (wleft != '0) begin
                            nxt_shreg = ld_data;
                            nxt_rd    = rd_ptr + 1'b1;
                            nxt_wleft = wleft - 1'b1;
                            nxt_tx    = ld_data[DATA_W-1 -: LANES];
                            ld_word   = 1'b1;
`ifdef FRAME_TX_CRC_EN
                            nxt_crc   = crc_upd(crc, ld_data);
`endif
                        end else begin
`ifdef FRAME_TX_CRC_EN
                            if (!crc_ph) begin
                                nxt_shreg  = DATA_W'(crc);
                                nxt_tx     = nxt_shreg[DATA_W-1 -: LANES];
                                nxt_crc_ph = 1'b1;
                            end else begin
                                go_gap = 1'b1;
                            end
`else
                            go_gap = 1'b1;
`endif
                        end
                    end else begin
                        nxt_slot  = slot_cnt + 1'b1;
                        nxt_shreg = shreg << LANES;
                        nxt_tx    = nxt_shreg[DATA_W-1 -: LANES];
                    end
                end
                if (go_gap) begin
                    nxt_state = GAP;
                    nxt_slot  = '0;
                    nxt_tx    = '0;
                    nxt_en    = 1'b0;
                    nxt_int   = 1'b1;
                    pop       = 1'b1;
                end
            end
            GAP: begin
                if (slot_end) begin
                    if (slot_cnt == GAP_LAST) begin
                        nxt_slot = '0;
                        if (d_cnt != '0) begin
                            nxt_state = PREAMBLE;
                            nxt_tx    = {LANES{1'b1}};
                            nxt_en    = 1'b1;
                        end else begin
                            nxt_state = IDLE;
                        end
                    end else begin
                        nxt_slot = slot_cnt + 1'b1;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // serializer state and registered TX outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            slot_cnt <= '0;
            wleft    <= '0;
            shreg    <= '0;
            rd_ptr   <= '0;
            o_tx     <= '0;
            o_tx_en  <= 1'b0;
            o_tx_int <= 1'b0;
`ifdef FRAME_TX_CRC_EN
            crc      <= '0;
            crc_ph   <= 1'b0;
`endif
        end else begin
            state    <= nxt_state;
            div_cnt  <= nxt_div;
            slot_cnt <= nxt_slot;
            wleft    <= nxt_wleft;
            shreg    <= nxt_shreg;
            rd_ptr   <= nxt_rd;
            o_tx     <= nxt_tx;
            o_tx_en  <= nxt_en;
            o_tx_int <= nxt_int;
`ifdef FRAME_TX_CRC_EN
            crc      <= nxt_crc;
            crc_ph   <= nxt_crc_ph;
`endif
        end
    end

    assign o_data_size    = unc_cnt;
    assign o_frames_count = d_cnt;
    assign o_status       = {2'b00, err_empty, err_ovf, (state != IDLE),
                             fifo_full, buf_full, (d_cnt == '0)};

endmodule

// File: tb/tb_frame_tx_mc.sv
// Directed bench for frame_tx_mc: one default instance and one with
// LANES=2, BIT_DIV=3. Outputs are logged every falling edge into arrays;
// each scenario task then compares the log against hand-derived values.
module tb_frame_tx_mc;

    localparam int LOGN = 256;
`ifdef FRAME_TX_CRC_EN
    localparam int CRC1 = 8;    // CRC word slots on the 1-lane instance
    localparam int CRC2 = 12;   // 4 slots x 3 cycles on the 2-lane instance
`else
    localparam int CRC1 = 0;
    localparam int CRC2 = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] data, b_data;
    logic we, push, rb, clr, b_we, b_push, b_rb, b_clr;
    logic [4:0] size, b_size;
    logic [2:0] fc, b_fc;
    logic [7:0] status, b_status;
    logic [0:0] tx;
    logic [1:0] b_tx;
    logic en, tint, b_en, b_int;

    int errors = 0;
    int checks = 0;
    int lc;

    logic       tx_log   [0:LOGN-1];
    logic       en_log   [0:LOGN-1];
    logic       int_log  [0:LOGN-1];
    logic       busy_log [0:LOGN-1];
    logic [2:0] fc_log   [0:LOGN-1];
    logic [1:0] tx2_log  [0:LOGN-1];
    logic       en2_log  [0:LOGN-1];
    logic       int2_log [0:LOGN-1];

    frame_tx_mc u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_data_we(we),
        .i_push_frame(push), .i_rollback(rb), .i_clr_err(clr),
        .o_data_size(size), .o_frames_count(fc), .o_status(status),
        .o_tx(tx), .o_tx_en(en), .o_tx_int(tint)
    );

    frame_tx_mc #(.LANES(2), .BIT_DIV(3)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(b_data), .i_data_we(b_we),
        .i_push_frame(b_push), .i_rollback(b_rb), .i_clr_err(b_clr),
        .o_data_size(b_size), .o_frames_count(b_fc), .o_status(b_status),
        .o_tx(b_tx), .o_tx_en(b_en), .o_tx_int(b_int)
    );

    always #5 clk = ~clk;

    // advance to the next falling edge and log both instances
    task automatic tick();
        @(negedge clk);
        if (lc < LOGN) begin
            tx_log[lc]   = tx[0];
            en_log[lc]   = en;
            int_log[lc]  = tint;
            busy_log[lc] = status[3];
            fc_log[lc]   = fc;
            tx2_log[lc]  = b_tx;
            en2_log[lc]  = b_en;
            int2_log[lc] = b_int;
        end
        lc++;
    endtask

    function automatic logic [7:0] byte_at(input int idx);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = tx_log[idx+i];
        return b;
    endfunction

    function automatic int count_en(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n && i < LOGN; i++) if (en_log[i]) c++;
        return c;
    endfunction

    function automatic int count_int(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n && i < LOGN; i++) if (int_log[i]) c++;
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (status !== 8'h01) begin errors++; $display("FAIL reset_status: got %h want 01", status); end
        checks++; if ({tx, en, tint} !== 3'b000) begin errors++; $display("FAIL reset_tx: got %b want 000", {tx, en, tint}); end
        checks++; if (size !== 5'd0 || fc !== 3'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", size, fc); end
        checks++; if (b_status !== 8'h01 || b_tx !== 2'b00) begin errors++; $display("FAIL reset_dut2: got %h/%b want 01/00", b_status, b_tx); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [19:0] got;
        lc = 0;
        data = 8'hA5; we = 1'b1; tick();
        data = 8'h3C; tick();
        we = 1'b0; push = 1'b1; tick();      // index 2: push sampled
        push = 1'b0;
        repeat (32 + CRC1) tick();
        checks++; if (fc_log[2] !== 3'd1 || en_log[2] !== 1'b0) begin errors++; $display("FAIL basic_commit: fc %0d en %b want 1 0", fc_log[2], en_log[2]); end
        checks++; if (en_log[3] !== 1'b1) begin errors++; $display("FAIL basic_latency: en %b want 1", en_log[3]); end
        for (int i = 0; i < 20; i++) got[19-i] = tx_log[3+i];
        checks++; if (got !== 20'hAA53C) begin errors++; $display("FAIL basic_bits: got %h want aa53c", got); end
        checks++; if (count_en(lc) != 20 + CRC1) begin errors++; $display("FAIL basic_en_len: got %0d want %0d", count_en(lc), 20 + CRC1); end
        checks++; if (int_log[23+CRC1] !== 1'b1 || count_int(lc) != 1) begin errors++; $display("FAIL basic_int: got %b x%0d want 1 x1", int_log[23+CRC1], count_int(lc)); end
        checks++; if (fc_log[22+CRC1] !== 3'd1 || fc_log[23+CRC1] !== 3'd0) begin errors++; $display("FAIL basic_fc_dec: got %0d->%0d want 1->0", fc_log[22+CRC1], fc_log[23+CRC1]); end
        checks++; if (busy_log[24+CRC1] !== 1'b1 || busy_log[25+CRC1] !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b%b want 10", busy_log[24+CRC1], busy_log[25+CRC1]); end
    endtask

    task automatic test_rollback();
        lc = 0;
        we = 1'b1;
        data = 8'h11; tick();
        data = 8'h22; tick();
        data = 8'h33; tick();
        we = 1'b0;
        checks++; if (size !== 5'd3) begin errors++; $display("FAIL rb_size_pre: got %0d want 3", size); end
        rb = 1'b1; tick(); rb = 1'b0;
        checks++; if (size !== 5'd0) begin errors++; $display("FAIL rb_size_post: got %0d want 0", size); end
        data = 8'h44; we = 1'b1; tick();
        rb = 1'b1; tick(); we = 1'b0; rb = 1'b0;
        checks++; if (size !== 5'd0) begin errors++; $display("FAIL rb_with_we: got %0d want 0", size); end
        repeat (10) tick();
        checks++; if (count_en(lc) != 0) begin errors++; $display("FAIL rb_no_tx: en cycles %0d want 0", count_en(lc)); end
        checks++; if (status !== 8'h01) begin errors++; $display("FAIL rb_status: got %h want 01", status); end
    endtask

    task automatic test_empty_push();
        push = 1'b1; tick(); push = 1'b0;
        checks++; if (status !== 8'h21 || fc !== 3'd0) begin errors++; $display("FAIL empty_push: got %h fc %0d want 21 0", status, fc); end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++; if (status[5] !== 1'b0) begin errors++; $display("FAIL empty_clr: got %b want 0", status[5]); end
        push = 1'b1; clr = 1'b1; tick(); push = 1'b0;
        checks++; if (status[5] !== 1'b1) begin errors++; $display("FAIL err_beats_clr: got %b want 1", status[5]); end
        tick(); clr = 1'b0;
        checks++; if (status !== 8'h01) begin errors++; $display("FAIL empty_clr2: got %h want 01", status); end
    endtask

    task automatic test_overflow();
        int p, bad;
        lc = 0;
        we = 1'b1;
        for (int i = 0; i < 15; i++) begin data = 8'hE0 ^ 8'(i); tick(); end
        checks++; if (status[1] !== 1'b0) begin errors++; $display("FAIL ovf_not_full: got %b want 0", status[1]); end
        data = 8'hE0 ^ 8'd15; tick();
        checks++; if (status[1] !== 1'b1 || size !== 5'd16 || status[4] !== 1'b0) begin errors++; $display("FAIL ovf_full: st %h size %0d want full 16 no ovf", status, size); end
        data = 8'h99; tick(); we = 1'b0;
        checks++; if (status[4] !== 1'b1 || size !== 5'd16) begin errors++; $display("FAIL ovf_drop: st %h size %0d want ovf 16", status, size); end
        push = 1'b1; tick(); push = 1'b0;
        p = lc - 1;
        repeat (140 + CRC1) tick();
        checks++; if (count_en(lc) != 132 + CRC1) begin errors++; $display("FAIL ovf_en_len: got %0d want %0d", count_en(lc), 132 + CRC1); end
        bad = 0;
        for (int k = 0; k < 16; k++) if (byte_at(p + 5 + 8*k) !== (8'hE0 ^ 8'(k))) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL ovf_words: %0d wrong words want 0", bad); end
        checks++; if (int_log[p+133+CRC1] !== 1'b1) begin errors++; $display("FAIL ovf_int: got %b want 1", int_log[p+133+CRC1]); end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++; if (status[4] !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", status[4]); end
    endtask

    task automatic test_back_to_back();
        int fp, bad, gbad;
        fp = 14 + CRC1;
        lc = 0;
        for (int i = 0; i < 5; i++) begin
            data = 8'h10 + 8'(i); we = 1'b1; push = 1'b1; tick();
        end
        we = 1'b0; push = 1'b0;
        checks++; if (status[2] !== 1'b1 || status[4] !== 1'b1) begin errors++; $display("FAIL b2b_fifo_full: st %h want bits 2,4 set", status); end
        checks++; if (fc !== 3'd4 || size !== 5'd1) begin errors++; $display("FAIL b2b_counts: fc %0d size %0d want 4 1", fc, size); end
        rb = 1'b1; tick(); rb = 1'b0;
        checks++; if (size !== 5'd0 || en !== 1'b1) begin errors++; $display("FAIL b2b_rb_busy: size %0d en %b want 0 1", size, en); end
        repeat (4*fp + 6) tick();
        checks++; if (count_int(lc) != 4) begin errors++; $display("FAIL b2b_int_cnt: got %0d want 4", count_int(lc)); end
        checks++; if (count_en(lc) != 4*(12 + CRC1)) begin errors++; $display("FAIL b2b_en_len: got %0d want %0d", count_en(lc), 4*(12 + CRC1)); end
        bad = 0;
        for (int k = 0; k < 4; k++) if (byte_at(5 + fp*k) !== 8'h10 + 8'(k)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_words: %0d wrong want 0", bad); end
        gbad = 0;
        for (int k = 1; k < 4; k++)
            if (en_log[fp*k-1] !== 1'b0 || en_log[fp*k] !== 1'b0 || en_log[fp*k+1] !== 1'b1) gbad++;
        checks++; if (gbad != 0) begin errors++; $display("FAIL b2b_gaps: %0d bad gaps want 0", gbad); end
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_lanes();
        int p, bad;
        logic [1:0] exp2 [4];
        exp2 = '{2'b11, 2'b00, 2'b01, 2'b10};
        lc = 0;
        b_data = 8'hC6; b_we = 1'b1; tick();
        b_we = 1'b0; b_push = 1'b1; tick(); b_push = 1'b0;
        p = lc - 1;
        repeat (30 + CRC2) tick();
        checks++; if (en2_log[p] !== 1'b0 || en2_log[p+1] !== 1'b1) begin errors++; $display("FAIL lanes_start: en %b%b want 01", en2_log[p], en2_log[p+1]); end
        checks++; if (tx2_log[p+1] !== 2'b11 || tx2_log[p+4] !== 2'b00) begin errors++; $display("FAIL lanes_pre: got %b %b want 11 00", tx2_log[p+1], tx2_log[p+4]); end
        for (int s = 0; s < 4; s++) begin
            bad = 0;
            for (int j = 0; j < 3; j++) if (tx2_log[p+13+3*s+j] !== exp2[s]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL lanes_slot%0d: got %b want %b", s, tx2_log[p+13+3*s], exp2[s]); end
        end
        checks++; if (en2_log[p+24+CRC2] !== 1'b1 || int2_log[p+25+CRC2] !== 1'b1) begin errors++; $display("FAIL lanes_end: en %b int %b want 1 1", en2_log[p+24+CRC2], int2_log[p+25+CRC2]); end
    endtask

`ifdef FRAME_TX_CRC_EN
    task automatic test_crc();
        int p;
        lc = 0;
        data = 8'h01; we = 1'b1; tick();
        we = 1'b0; push = 1'b1; tick(); push = 1'b0;
        p = lc - 1;
        repeat (30) tick();
        checks++; if (byte_at(p+5) !== 8'h01) begin errors++; $display("FAIL crc_data: got %h want 01", byte_at(p+5)); end
        checks++; if (byte_at(p+13) !== 8'h07) begin errors++; $display("FAIL crc_word: got %h want 07", byte_at(p+13)); end
        checks++; if (int_log[p+21] !== 1'b1) begin errors++; $display("FAIL crc_int: got %b want 1", int_log[p+21]); end
    endtask
`endif

    task automatic test_reset_mid();
        int p;
        lc = 0;
        data = 8'hFF; we = 1'b1; tick();
        we = 1'b0; push = 1'b1; tick(); push = 1'b0;
        p = lc - 1;
        repeat (7) tick();
        checks++; if (en_log[p+7] !== 1'b1 || tx_log[p+7] !== 1'b1) begin errors++; $display("FAIL mid_pre: en %b tx %b want 1 1", en_log[p+7], tx_log[p+7]); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b0 || en !== 1'b0 || tint !== 1'b0) begin errors++; $display("FAIL mid_tx: got %b%b%b want 000", tx, en, tint); end
        checks++; if (fc !== 3'd0 || size !== 5'd0 || status !== 8'h01) begin errors++; $display("FAIL mid_counts: fc %0d size %0d st %h want 0 0 01", fc, size, status); end
        @(negedge clk);
        rst_n = 1'b1;
        lc = 0;
        repeat (20) tick();
        checks++; if (count_en(lc) != 0 || fc !== 3'd0) begin errors++; $display("FAIL mid_aborted: en cycles %0d fc %0d want 0 0", count_en(lc), fc); end
    endtask

    initial begin
        rst_n = 1'b0;
        data = 8'h00; we = 1'b0; push = 1'b0; rb = 1'b0; clr = 1'b0;
        b_data = 8'h00; b_we = 1'b0; b_push = 1'b0; b_rb = 1'b0; b_clr = 1'b0;
        lc = 0;
        test_reset();
        test_basic();
        test_rollback();
        test_empty_push();
        test_overflow();
        test_back_to_back();
        test_lanes();
`ifdef FRAME_TX_CRC_EN
        test_crc();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
